// File: rtl/ddc_frame_rx.sv
// Reassembles N_CH-beat DDC bursts into channel-tagged frames, buffers whole frames
// in a commit-on-last-beat FIFO and replays them on a back-pressurable AXI-Stream.
module ddc_frame_rx #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 64
) (
  input  logic         s_axis_aclk,
  input  logic         rst,
  input  logic [95:0]  s_axis_ddc_tdata,
  input  logic         s_axis_ddc_tvalid,
  input  logic         enable,
  output logic [127:0] m_axis_tdata,
  output logic [31:0]  m_axis_tuser,
  output logic         m_axis_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [31:0]  frame_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] MAX_USED = PW'(DEPTH - N_CH);
  localparam logic [8:0]    LAST_BC  = 9'(N_CH - 1);
  localparam logic [7:0]    LAST_CH  = 8'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t        state, state_n;
  logic [PW-1:0] wr, wr_n, wc, wc_n, rd;
  logic [8:0]    bc, bc_n;
  logic [31:0]   frame_cnt_n, drop_cnt_n, err_cnt_n;
  logic          has_space;

  logic                we_p0;
  logic [159:0]        wdata_p0;
  logic signed [47:0]  i_acc, q_acc;

  logic [159:0] mem [DEPTH];
  logic [159:0] rd_word;
  logic         load;

  logic [127:0] data_p1;
  logic [31:0]  user_p1;
  logic         last_p1, vld_p1;

  function automatic logic [159:0] pack_beat(input logic [7:0] ch, input logic [31:0] idx,
                                             input logic signed [47:0] q,
                                             input logic signed [47:0] i);
    return {idx, 24'd0, ch, q, i};
  endfunction

  assign i_acc = s_axis_ddc_tdata[47:0];
  assign q_acc = s_axis_ddc_tdata[95:48];

  // Space is judged against committed data only; a read in the same cycle is not credited.
  assign has_space = (wc - rd) <= MAX_USED;

  // Stage p0: frame assembly into the shadow region of the FIFO
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr        <= '0;
      wc        <= '0;
      bc        <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      wr        <= wr_n;
      wc        <= wc_n;
      bc        <= bc_n;
      frame_cnt <= frame_cnt_n;
      drop_cnt  <= drop_cnt_n;
      err_cnt   <= err_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    wr_n        = wr;
    wc_n        = wc;
    bc_n        = bc;
    frame_cnt_n = frame_cnt;
    drop_cnt_n  = drop_cnt;
    err_cnt_n   = err_cnt;
    we_p0       = 1'b0;
    wdata_p0    = pack_beat(bc[7:0], frame_cnt, q_acc, i_acc);
    case (state)
      IDLE: begin
        if (s_axis_ddc_tvalid) begin
          if (enable && has_space) begin
            we_p0    = 1'b1;
            wdata_p0 = pack_beat(8'd0, frame_cnt, q_acc, i_acc);
            wr_n     = wr + PTR_ONE;
            if (N_CH == 1) begin
              wc_n        = wr + PTR_ONE;
              frame_cnt_n = frame_cnt + 32'd1;
            end else begin
              bc_n    = 9'd1;
              state_n = RECV;
            end
          end else begin
            if (enable) drop_cnt_n = drop_cnt + 32'd1;
            if (N_CH > 1) begin
              bc_n    = 9'd1;
              state_n = DISCARD;
            end
          end
        end
      end
      RECV: begin
        if (s_axis_ddc_tvalid) begin
          we_p0 = 1'b1;
          wr_n  = wr + PTR_ONE;
          if (bc == LAST_BC) begin
            wc_n        = wr + PTR_ONE;
            frame_cnt_n = frame_cnt + 32'd1;
            bc_n        = '0;
            state_n     = IDLE;
          end else begin
            bc_n = bc + 9'd1;
          end
        end else begin
          // Truncated frame: forget the shadow writes.
          wr_n      = wc;
          err_cnt_n = err_cnt + 32'd1;
          bc_n      = '0;
          state_n   = IDLE;
        end
      end
      DISCARD: begin
        if (s_axis_ddc_tvalid) begin
          if (bc == LAST_BC) begin
            bc_n    = '0;
            state_n = IDLE;
          end else begin
            bc_n = bc + 9'd1;
          end
        end else begin
          err_cnt_n = err_cnt + 32'd1;
          bc_n      = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (we_p0) mem[wr[AW-1:0]] <= wdata_p0;
  end

  // Stage p1: registered read of committed beats
  assign rd_word = mem[rd[AW-1:0]];
  assign load    = (!vld_p1 || m_axis_tready) && (rd != wc);

  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      rd      <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      user_p1 <= '0;
    end else if (load) begin
      rd      <= rd + PTR_ONE;
      vld_p1  <= 1'b1;
      last_p1 <= (rd_word[103:96] == LAST_CH);
      data_p1 <= rd_word[127:0];
      user_p1 <= rd_word[159:128];
    end else if (m_axis_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_axis_tdata  = data_p1;
  assign m_axis_tuser  = user_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tvalid = vld_p1;

endmodule

// File: tb/tb_ddc_frame_rx.sv
// Scoreboard bench for ddc_frame_rx: frame-level reference model feeds an expected-beat
// queue, an independent monitor pops it on every output handshake.
module tb_ddc_frame_rx;
  localparam int N_CH  = 4;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  s_tdata;
  logic         s_tvalid;
  logic         enable;
  logic [127:0] m_tdata;
  logic [31:0]  m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [31:0]  frame_cnt, drop_cnt, err_cnt;

  ddc_frame_rx #(.N_CH(N_CH), .DEPTH(DEPTH)) dut (
    .s_axis_aclk       (clk),
    .rst               (rst),
    .s_axis_ddc_tdata  (s_tdata),
    .s_axis_ddc_tvalid (s_tvalid),
    .enable            (enable),
    .m_axis_tdata      (m_tdata),
    .m_axis_tuser      (m_tuser),
    .m_axis_tlast      (m_tlast),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .frame_cnt         (frame_cnt),
    .drop_cnt          (drop_cnt),
    .err_cnt           (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [31:0]  user;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_frame = 0, m_drop = 0, m_err = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output monitor
  initial begin
    exp_t         e;
    logic         stall;
    logic [127:0] st_data;
    logic [31:0]  st_user;
    stall = 1'b0;
    st_data = '0;
    st_user = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", {127'd0, m_tvalid}, 128'd1);
          chk("hold_data", m_tdata, st_data);
          chk("hold_user", {96'd0, m_tuser}, {96'd0, st_user});
        end
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h user %0d, expected no beat", m_tdata, m_tuser);
          end else begin
            e = sb.pop_front();
            chk("beat_data", m_tdata, e.data);
            chk("beat_user", {96'd0, m_tuser}, {96'd0, e.user});
            chk("beat_last", {127'd0, m_tlast}, {127'd0, (e.data[103:96] == 8'(N_CH - 1))});
          end
        end
        stall   = m_tvalid && !m_tready;
        st_data = m_tdata;
        st_user = m_tuser;
      end
    end
  end

  task automatic drive(input logic v, input logic [95:0] d);
    s_tvalid = v;
    s_tdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0);
  endtask

  // One burst of nb beats. adm is the model's admission decision for this frame.
  task automatic send_frame(input int nb, input bit en, input bit adm, input bit pat);
    exp_t               fr[$];
    exp_t               e;
    logic signed [47:0] iv, qv;
    enable = en;
    if (en && !adm) m_drop++;
    for (int c = 0; c < nb; c++) begin
      if (pat) begin
        iv = 48'(c * 16 + 1);
        qv = -48'(c + 1);
      end else begin
        iv = {16'($urandom), 32'($urandom)};
        qv = {16'($urandom), 32'($urandom)};
      end
      e.data = {24'd0, 8'(c), qv, iv};
      e.user = 32'(m_frame);
      fr.push_back(e);
      drive(1'b1, {qv, iv});
    end
    if (nb < N_CH) begin
      m_err++;
      idle(1);
    end else if (en && adm) begin
      foreach (fr[k]) sb.push_back(fr[k]);
      m_frame++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d beats still outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    idle(6);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_frame_cnt"}, {96'd0, frame_cnt}, 128'(m_frame));
    chk({tag, "_drop_cnt"}, {96'd0, drop_cnt}, 128'(m_drop));
    chk({tag, "_err_cnt"}, {96'd0, err_cnt}, 128'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int adm_cnt, stored, w, nb;
    bit adm, en;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", {127'd0, m_tvalid}, 128'd0);
    chk("rst_tlast", {127'd0, m_tlast}, 128'd0);
    chk("rst_tdata", m_tdata, 128'd0);
    chk("rst_tuser", {96'd0, m_tuser}, 128'd0);
    chk_counters("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single patterned frame, first output one cycle after the last input beat
    send_frame(N_CH, 1'b1, 1'b1, 1'b1);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("lat_pre", {127'd0, m_tvalid}, 128'd0);
    @(negedge clk);
    chk("lat_first", {127'd0, m_tvalid}, 128'd1);
    wait_drain("single_drain");
    chk_counters("single");

    // Ten back-to-back frames with random back-pressure
    rdy_mode = 1;
    for (int f = 0; f < 10; f++) send_frame(N_CH, 1'b1, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    wait_drain("b2b_drain");
    chk_counters("b2b");
    rdy_mode = 0;

    // Gap after two beats, then a full frame
    send_frame(2, 1'b1, 1'b1, 1'b0);
    send_frame(N_CH, 1'b1, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    wait_drain("gap_drain");
    chk_counters("gap");

    // Disabled frame followed by an enabled one
    send_frame(N_CH, 1'b0, 1'b1, 1'b0);
    send_frame(N_CH, 1'b1, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    wait_drain("enable_drain");
    chk_counters("enable");

    // Overflow with the output stalled; one beat always sits in the output register
    rdy_mode = 2;
    idle(2);
    adm_cnt = 0;
    for (int f = 0; f < DEPTH / N_CH + 2; f++) begin
      stored = adm_cnt * N_CH - ((adm_cnt > 0) ? 1 : 0);
      adm = (DEPTH - stored) >= N_CH;
      send_frame(N_CH, 1'b1, adm, 1'b0);
      if (adm) adm_cnt++;
    end
    s_tvalid = 1'b0;
    idle(3);
    chk("ovf_drop_cnt", {96'd0, drop_cnt}, 128'(m_drop));
    rdy_mode = 0;
    wait_drain("ovf_drain");
    chk_counters("ovf");

    // Randomized traffic: truncations, disabled frames, idle gaps, random back-pressure
    for (int f = 0; f < 40; f++) begin
      rdy_mode = int'($urandom_range(0, 1));
      w = 0;
      while (sb.size() > DEPTH - N_CH && w < 500) begin
        idle(1);
        w++;
      end
      if (w >= 500) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_space: %0d beats outstanding, expected at most %0d", sb.size(), DEPTH - N_CH);
      end
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N_CH - 1)) : N_CH;
      en = ($urandom_range(0, 9) != 0);
      send_frame(nb, en, 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    s_tvalid = 1'b0;
    rdy_mode = 0;
    wait_drain("rand_drain");
    chk_counters("rand");

    // Reset while frames are pending at the output
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) send_frame(N_CH, 1'b1, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    idle(2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rstmid_tvalid", {127'd0, m_tvalid}, 128'd0);
    sb.delete();
    m_frame = 0;
    m_drop = 0;
    m_err = 0;
    chk_counters("rstmid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    send_frame(N_CH, 1'b1, 1'b1, 1'b1);
    s_tvalid = 1'b0;
    wait_drain("post_rst_drain");
    chk_counters("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
